// File: rtl/cond_entrada_pkg.sv
// Shared types for the cond_entrada input conditioner: debounce FSM state
// encoding and the counter width helper.
package cond_entrada_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'b00,
    RISE_CHK = 2'b01,
    HIGH     = 2'b11,
    FALL_CHK = 2'b10
  } state_t;

  localparam logic [7:0] GLITCH_MAX = 8'd255;

  // Counter only has to reach DB_CYCLES-1.
  function automatic int cnt_w(input int db_cycles);
    return $clog2(db_cycles);
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Flop-chain synchroniser for one asynchronous level; latency SYNC_STAGES edges.
// No backpressure: free-running, cleared to 0 by synchronous reset r.
module sincronizador #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic r,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (r) chain <= '0;
    else   chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cond_entrada.sv
// Synchronise + debounce btn into level x with 1-cycle rise/fall pulses; latency SYNC_STAGES+DB_CYCLES edges.
// No backpressure (level path). Optional glitch_cnt port under `GLITCH_CNT_EN.
module cond_entrada
  import cond_entrada_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       r,
  input  logic       btn,
  output logic       x,
  output logic       rise,
  output logic       fall
`ifdef GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s;
  state_t        state;
  logic [CW-1:0] cnt;

  sincronizador #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .r   (r),
    .d   (btn),
    .q   (s)
  );

  always_ff @(posedge clk) begin
    if (r) begin
      state <= LOW;
      cnt   <= '0;
      x     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        LOW: begin
          if (s) begin
            state <= RISE_CHK;
            cnt   <= CW'(1);
          end
        end
        RISE_CHK: begin
          if (!s) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HIGH;
            cnt   <= '0;
            x     <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!s) begin
            state <= FALL_CHK;
            cnt   <= CW'(1);
          end
        end
        FALL_CHK: begin
          if (s) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= LOW;
            cnt   <= '0;
            x     <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef GLITCH_CNT_EN
  // An abort is a check state seeing the input revert before acceptance.
  logic abort;
  assign abort = ((state == RISE_CHK) && !s) || ((state == FALL_CHK) && s);

  always_ff @(posedge clk) begin
    if (r)                                     glitch_cnt <= '0;
    else if (abort && glitch_cnt != GLITCH_MAX) glitch_cnt <= glitch_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_cond_entrada.sv
// Directed self-checking bench for cond_entrada (default params); define
// GLITCH_CNT_EN to also exercise the glitch counter.
module tb_cond_entrada;
  import cond_entrada_pkg::*;

  logic clk = 1'b0;
  logic r   = 1'b1;
  logic btn = 1'b0;
  logic x, rise, fall;
`ifdef GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cond_entrada #(.SYNC_STAGES(2), .DB_CYCLES(4)) dut (
    .clk  (clk),
    .r    (r),
    .btn  (btn),
    .x    (x),
    .rise (rise),
    .fall (fall)
`ifdef GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock edge, then check outputs 1 time unit later.
  task automatic tick(input string tag, input logic ex, input logic er, input logic ef);
    @(posedge clk);
    #1;
    chk({tag, ".x"}, {31'd0, x}, {31'd0, ex});
    chk({tag, ".rise"}, {31'd0, rise}, {31'd0, er});
    chk({tag, ".fall"}, {31'd0, fall}, {31'd0, ef});
  endtask

  initial begin
    // 1: reset with btn high
    r = 1'b1; btn = 1'b1;
    tick("rst0", 1'b0, 1'b0, 1'b0);
    chk("rst0.state", {30'd0, dut.state}, {30'd0, LOW});
    tick("rst1", 1'b0, 1'b0, 1'b0);
    chk("rst1.state", {30'd0, dut.state}, {30'd0, LOW});
    r = 1'b0; btn = 1'b0;
    repeat (3) tick("idle", 1'b0, 1'b0, 1'b0);

    // 3: 2-cycle pulse is rejected
    btn = 1'b1;
    repeat (2) tick("short_hi", 1'b0, 1'b0, 1'b0);
    btn = 1'b0;
    repeat (6) tick("short_lo", 1'b0, 1'b0, 1'b0);
`ifdef GLITCH_CNT_EN
    chk("short.glitch_cnt", {24'd0, glitch_cnt}, 32'd1);
`endif

    // 2: held high -> rise after 6th edge
    btn = 1'b1;
    repeat (5) tick("rise_wait", 1'b0, 1'b0, 1'b0);
    tick("rise_e6", 1'b1, 1'b1, 1'b0);
    repeat (3) tick("rise_hold", 1'b1, 1'b0, 1'b0);

    // 4: bounce 0-1-0-1 then stay 0 -> single fall 6 edges after last 1->0
    btn = 1'b0; tick("bnc0", 1'b1, 1'b0, 1'b0);
    btn = 1'b1; tick("bnc1", 1'b1, 1'b0, 1'b0);
    btn = 1'b0; tick("bnc2", 1'b1, 1'b0, 1'b0);
    btn = 1'b1; tick("bnc3", 1'b1, 1'b0, 1'b0);
    btn = 1'b0;
    repeat (5) tick("fall_wait", 1'b1, 1'b0, 1'b0);
    tick("fall_e6", 1'b0, 1'b0, 1'b1);
    repeat (3) tick("fall_hold", 1'b0, 1'b0, 1'b0);
`ifdef GLITCH_CNT_EN
    chk("bounce.glitch_cnt", {24'd0, glitch_cnt}, 32'd3);
`endif

    // 5: reset mid RISE_CHK
    btn = 1'b1;
    repeat (4) tick("chk_pre", 1'b0, 1'b0, 1'b0);
    chk("mid.state", {30'd0, dut.state}, {30'd0, RISE_CHK});
    chk("mid.cnt", {30'd0, dut.cnt}, 32'd2);
    r = 1'b1;
    tick("mid_rst", 1'b0, 1'b0, 1'b0);
    chk("mid_rst.state", {30'd0, dut.state}, {30'd0, LOW});
    chk("mid_rst.cnt", {30'd0, dut.cnt}, 32'd0);
`ifdef GLITCH_CNT_EN
    chk("mid_rst.glitch_cnt", {24'd0, glitch_cnt}, 32'd0);
`endif
    r = 1'b0; btn = 1'b0;
    repeat (4) tick("post_rst", 1'b0, 1'b0, 1'b0);
    chk("post_rst.state", {30'd0, dut.state}, {30'd0, LOW});

`ifdef GLITCH_CNT_EN
    // 6: 300 single-cycle glitches saturate the counter
    for (int i = 0; i < 300; i++) begin
      btn = 1'b1; tick("sat_hi", 1'b0, 1'b0, 1'b0);
      btn = 1'b0; tick("sat_lo", 1'b0, 1'b0, 1'b0);
      tick("sat_lo2", 1'b0, 1'b0, 1'b0);
    end
    repeat (4) tick("sat_end", 1'b0, 1'b0, 1'b0);
    chk("sat.glitch_cnt", {24'd0, glitch_cnt}, 32'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
